// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI shift logic and the RAM slave.
// The master drives command words and transmit acceptance. The slave
// returns read data, its valid flag and the sticky overrun flag.
interface spi_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    rx_valid;
    logic [DATA_WIDTH+1:0]   din;
    logic                    tx_ready;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    tx_valid;
    logic                    overrun;

    modport master (
        output rx_valid, din, tx_ready,
        input  dout, tx_valid, overrun
    );

    modport slave (
        input  rx_valid, din, tx_ready,
        output dout, tx_valid, overrun
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port RAM slave behind the SPI shift logic.
// It decodes 2-bit-opcode command words: set write address, write data,
// set read address and read data. Read data is returned over a
// valid/ready handshake, and a sticky overrun flag records dropped reads.
// Optional macro SPI_RAM_AUTO_INC_EN adds post-increment of the write
// address after each write command and of the read address after each
// accepted read, with wrap to 0.
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_ctrl_if.slave   bus
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0]  w_addr;
    logic [ADDR_SIZE-1:0]  r_addr;

    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0]  addr_field;
    logic                  w_in_range;
    logic                  r_in_range;
    logic                  wr_cmd;
    logic                  do_write;
    logic                  rd_cmd;
    logic                  rd_accept;
    logic                  rd_drop;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef SPI_RAM_AUTO_INC_EN
    // Wraps from the last word, and any out-of-range address restarts at 0.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) >= MEM_DEPTH - 1)
            return '0;
        else
            return a + 1'b1;
    endfunction
`endif

    // Split the command word and decide which command executes this cycle.
    always_comb begin
        opcode     = bus.din[DATA_WIDTH+1:DATA_WIDTH];
        payload    = bus.din[DATA_WIDTH-1:0];
        addr_field = payload[ADDR_SIZE-1:0];
        w_in_range = (32'(w_addr) < MEM_DEPTH);
        r_in_range = (32'(r_addr) < MEM_DEPTH);
        wr_cmd     = bus.rx_valid && (opcode == OP_WRITE);
        do_write   = wr_cmd && w_in_range;
        rd_cmd     = bus.rx_valid && (opcode == OP_READ);
        // A read may replace held data only when that data leaves this cycle.
        rd_accept  = rd_cmd && (!bus.tx_valid || bus.tx_ready);
        rd_drop    = rd_cmd && bus.tx_valid && !bus.tx_ready;
        rd_data    = r_in_range ? mem[r_addr[MEM_AW-1:0]] : '0;
    end

    // Memory array, never reset; out-of-range writes are discarded.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[w_addr[MEM_AW-1:0]] <= payload;
    end

    // Address registers, read-data handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr       <= '0;
            r_addr       <= '0;
            bus.dout     <= '0;
            bus.tx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (bus.rx_valid && (opcode == OP_SET_WADDR))
                w_addr <= addr_field;
`ifdef SPI_RAM_AUTO_INC_EN
            else if (wr_cmd)
                w_addr <= next_addr(w_addr);
`endif

            if (bus.rx_valid && (opcode == OP_SET_RADDR))
                r_addr <= addr_field;
`ifdef SPI_RAM_AUTO_INC_EN
            else if (rd_accept)
                r_addr <= next_addr(r_addr);
`endif

            if (rd_accept) begin
                bus.dout     <= rd_data;
                bus.tx_valid <= 1'b1;
            end else if (bus.tx_ready) begin
                bus.tx_valid <= 1'b0;
            end

            if (rd_drop)
                bus.overrun <= 1'b1;
        end
    end

endmodule
